cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Writeback stage directly downstream of execute. Buffers the per-FU result packets
//  (add, mul, div, br) in small per-source FIFOs and broadcasts up to NUM_CDB of them
//  per cycle on the common data bus to the ROB, reservation stations and phys regfile.
//  Issues per-FU stall back to issue so no result is lost, and discards all buffered
//  results on a pipeline flush.
// PARAMETERS
//  FIFO_DEPTH   4  entries per source FIFO (power of two, >=2)
//  NUM_CDB      2  broadcast ports per cycle (1..4)
//  SKID         1  slots reserved per FIFO for results already in flight when stall rises
//  BR_PRIORITY  1  1: branch source is scanned first every cycle; 0: pure round-robin
// PORTS
//  clk                 in   1            clock
//  rst                 in   1            synchronous active-high reset
//  flush               in   1            global_branch_signal; discard everything
//  cdb_in[4]           in   4 x cdb_t    per-source results; index 0 add,1 mul,2 div,3 br
//  cdb_out[NUM_CDB]    out  NUM_CDB x cdb_t  broadcast packets; .valid qualifies each
//  fu_stall[4]         out  4            per-source: do not start new op on this FU
//  overflow_err        out  1            sticky: a valid result arrived at a full FIFO
// BEHAVIOUR
//  - Push: cdb_in[i].valid && !flush -> cdb_in[i] written to FIFO i at edge; whole packet stored.
//  - Latency: packet pushed at end of cycle N is eligible for broadcast in cycle N+1
//    (no same-cycle bypass). cdb_out is combinational from FIFO heads + grant logic.
//  - Grant: scan order starts at rr_ptr (0..3), wrapping mod 4; if BR_PRIORITY, source 3
//    goes first and is skipped in the rotated scan. First NUM_CDB non-empty sources are
//    granted; k-th grant drives cdb_out[k]; cdb_out[k]=0 ('0, valid=0) if fewer grants.
//  - rr_ptr: after a cycle with >=1 non-br grant, advances to (last granted non-br src+1) mod 4;
//    otherwise holds. Reset value 0.
//  - Pop: every granted FIFO pops its head at the edge. Simultaneous push+pop on same FIFO
//    legal at any occupancy including full (count unchanged).
//  - Count per FIFO 0..FIFO_DEPTH, pointers wrap mod FIFO_DEPTH.
//  - fu_stall[i] = (count_i >= FIFO_DEPTH-SKID) -- registered-state based, no dependence on
//    same-cycle push/pop. Reset 0.
//  - Full: push when count==FIFO_DEPTH and no pop that cycle -> packet dropped, FIFO
//    unchanged, overflow_err set; cleared only by rst (not by flush).
//  - Flush: all counts/pointers -> 0 at edge; inputs of that cycle ignored; all cdb_out
//    valid forced 0 combinationally during the flush cycle; rr_ptr -> 0.
//  - Reset (any time, incl. mid-drain): same as flush plus overflow_err<=0. All outputs
//    0 while rst high.
//  - Ordering: per-source FIFO order preserved; no ordering guarantee across sources.
// STRUCTURE
//  - rv32i_types: add CDB_SRC_ADD/MUL/DIV/BR = 0..3, CDB_NUM_SRC=4, NUM_CDB default;
//    cdb_t reused unchanged.
//  - Sub-module cdb_src_fifo (cdb_t payload, push/pop/flush, count out); 4 instances.
//  - Top holds rr_ptr, grant scan (for-loop priority chain), output mux, overflow flag.
// TESTING
//  - Single add result rob_idx=5 rd_v=0x1234 at cycle 10 -> cdb_out[0] valid cycle 11
//    with same fields, cdb_out[1].valid=0, FIFO empty at 12.
//  - All four valid in one cycle, NUM_CDB=2, BR_PRIORITY=1, rr_ptr=0 -> cycle+1: br, add;
//    cycle+2: mul, div; rr_ptr ends at 3.
//  - 4 consecutive mul results, no pops possible (NUM_CDB=1, br/add also busy) ->
//    fu_stall[1] rises once count=3; 5th push at full -> dropped, overflow_err=1 sticky.
//  - FIFO full with push+pop same cycle -> no drop, count stays 4, overflow_err stays 0.
//  - 3 packets buffered, flush with new valid inputs same cycle -> no cdb_out valid that
//    cycle or next; all counts 0; overflow_err unchanged.
//  - rst asserted while two FIFOs non-empty -> all outputs 0, rr_ptr 0, next push after
//    rst deasserts broadcasts 1 cycle later.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the writeback / common-data-bus stage.
//   cdb_t       : result packet broadcast on the CDB (valid qualifies the packet)
//   cdb_src_e   : source index of each functional unit feeding the arbiter
//   CDB_NUM_SRC : number of result sources
package cdb_arbiter_pkg;

    localparam int unsigned ROB_IDX_W       = 5;
    localparam int unsigned PREG_W          = 6;
    localparam int unsigned CDB_NUM_SRC     = 4;
    localparam int unsigned NUM_CDB_DEFAULT = 2;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [31:0]          rd_v;
    } cdb_t;

    typedef enum logic [1:0] {
        CDB_SRC_ADD = 2'd0,
        CDB_SRC_MUL = 2'd1,
        CDB_SRC_DIV = 2'd2,
        CDB_SRC_BR  = 2'd3
    } cdb_src_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : discard all entries at the edge
//   push, din  : write request and packet
//   pop        : release head at the edge (ignored when empty)
//   head       : current oldest packet (combinational)
//   count      : occupancy 0..DEPTH
// A push while full is only accepted when the head pops in the same cycle.
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  cdb_t                   din,
    input  logic                   pop,
    output cdb_t                   head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    cdb_t           mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic           full;
    logic           do_pop;
    logic           do_push;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0) && !flush && !rst;
    assign do_push = push && (!full || do_pop) && !flush && !rst;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Writeback arbiter: buffers add/mul/div/br results and broadcasts up to NUM_CDB
// of them per cycle on the common data bus.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : discard all buffered results, suppress broadcast this cycle
//   cdb_in[4]     : per-source results (0 add, 1 mul, 2 div, 3 br)
//   cdb_out[N]    : broadcast packets, k-th grant on port k, '0 when unused
//   fu_stall[4]   : per-source back-pressure from registered occupancy
//   overflow_err  : sticky, a valid result hit a full FIFO with no pop
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned NUM_CDB     = NUM_CDB_DEFAULT,
    parameter int unsigned SKID        = 1,
    parameter bit          BR_PRIORITY = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  cdb_t                   cdb_in   [CDB_NUM_SRC],
    output cdb_t                   cdb_out  [NUM_CDB],
    output logic [CDB_NUM_SRC-1:0] fu_stall,
    output logic                   overflow_err
);

    localparam int unsigned   CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] STALL_AT = CW'(FIFO_DEPTH - SKID);
    localparam logic [CW-1:0] FULL_AT  = CW'(FIFO_DEPTH);

    cdb_t                   head  [CDB_NUM_SRC];
    logic [CW-1:0]          count [CDB_NUM_SRC];
    logic [CDB_NUM_SRC-1:0] push;
    logic [CDB_NUM_SRC-1:0] nonempty;
    logic [CDB_NUM_SRC-1:0] grant;
    logic [CDB_NUM_SRC-1:0] drop;
    logic [1:0]             rr_ptr;
    logic [1:0]             rr_next;
    logic [1:0]             src;
    int unsigned            n_grant;
    logic                   overflow_q;

    for (genvar i = 0; i < CDB_NUM_SRC; i++) begin : g_src
        assign push[i]     = cdb_in[i].valid && !flush;
        assign nonempty[i] = (count[i] != '0);
        assign drop[i]     = push[i] && (count[i] == FULL_AT) && !grant[i];
        assign fu_stall[i] = !rst && (count[i] >= STALL_AT);

        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .din   (cdb_in[i]),
            .pop   (grant[i]),
            .head  (head[i]),
            .count (count[i])
        );
    end

    // Priority chain: optional branch slot first, then a rotated scan from rr_ptr.
    // n_grant selects which output port the next winner lands on.
    always_comb begin
        grant   = '0;
        rr_next = rr_ptr;
        n_grant = 0;
        src     = '0;
        for (int unsigned k = 0; k < NUM_CDB; k++) cdb_out[k] = '0;
        if (!rst && !flush) begin
            if (BR_PRIORITY && nonempty[CDB_SRC_BR]) begin
                grant[CDB_SRC_BR] = 1'b1;
                cdb_out[0]        = head[CDB_SRC_BR];
                n_grant           = 1;
            end
            for (int unsigned off = 0; off < CDB_NUM_SRC; off++) begin
                src = rr_ptr + 2'(off);
                if (!(BR_PRIORITY && (src == CDB_SRC_BR)) && nonempty[src]
                    && (n_grant < NUM_CDB)) begin
                    grant[src] = 1'b1;
                    for (int unsigned k = 0; k < NUM_CDB; k++) begin
                        if (k == n_grant) cdb_out[k] = head[src];
                    end
                    n_grant = n_grant + 1;
                    if (src != CDB_SRC_BR) rr_next = src + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_ptr     <= flush ? 2'd0 : rr_next;
            overflow_q <= overflow_q | (|drop);
        end
    end

    assign overflow_err = overflow_q && !rst;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    cdb_t        cdb_in  [CDB_NUM_SRC];
    cdb_t        cdb_out [NC];
    logic [3:0]  fu_stall;
    logic        overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .FIFO_DEPTH  (4),
        .NUM_CDB     (NC),
        .SKID        (1),
        .BR_PRIORITY (1'b1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .cdb_in       (cdb_in),
        .cdb_out      (cdb_out),
        .fu_stall     (fu_stall),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic [3:0] mask;
        logic [1:0] rr;
        logic       v0;
        logic [1:0] s0;
        int         q0;
        logic       v1;
        logic [1:0] s1;
        int         q1;
        logic [3:0] stall;
        logic       ovf;
    } vec_t;

    vec_t tbl [18];

    function automatic cdb_t mk(input logic [1:0] s, input int seq);
        cdb_t p;
        p.valid   = 1'b1;
        p.rob_idx = 5'(seq);
        p.pd      = {s, 4'(seq)};
        p.rd_v    = {16'hC0DE, 6'd0, s, 8'(seq)};
        return p;
    endfunction

    task automatic chk_pkt(input string name, input cdb_t act, input cdb_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] mask, input int seq);
        for (int unsigned i = 0; i < CDB_NUM_SRC; i++)
            cdb_in[i] = mask[i] ? mk(2'(i), seq) : cdb_t'('0);
    endtask

    task automatic chk_idle(input string name);
        chk_pkt({name, " out0"}, cdb_out[0], '0);
        chk_pkt({name, " out1"}, cdb_out[1], '0);
    endtask

    initial begin
        cdb_t pkt;
        cdb_t e0;
        cdb_t e1;

        // mask, rr, out0 {v,src,seq}, out1 {v,src,seq}, fu_stall, overflow_err
        tbl[0]  = '{4'b1111, 2'd0, 1'b0, 2'd0, 0,  1'b0, 2'd0, 0,  4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 2'd0, 1'b1, 2'd3, 0,  1'b1, 2'd0, 0,  4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 2'd1, 1'b1, 2'd1, 0,  1'b1, 2'd2, 0,  4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 2'd3, 1'b0, 2'd0, 0,  1'b0, 2'd0, 0,  4'b0000, 1'b0};
        tbl[4]  = '{4'b1011, 2'd3, 1'b0, 2'd0, 0,  1'b0, 2'd0, 0,  4'b0000, 1'b0};
        tbl[5]  = '{4'b1011, 2'd3, 1'b1, 2'd3, 4,  1'b1, 2'd0, 4,  4'b0000, 1'b0};
        tbl[6]  = '{4'b1011, 2'd1, 1'b1, 2'd3, 5,  1'b1, 2'd1, 4,  4'b0000, 1'b0};
        tbl[7]  = '{4'b1011, 2'd2, 1'b1, 2'd3, 6,  1'b1, 2'd0, 5,  4'b0000, 1'b0};
        tbl[8]  = '{4'b1011, 2'd1, 1'b1, 2'd3, 7,  1'b1, 2'd1, 5,  4'b0010, 1'b0};
        tbl[9]  = '{4'b1011, 2'd2, 1'b1, 2'd3, 8,  1'b1, 2'd0, 6,  4'b0011, 1'b0};
        tbl[10] = '{4'b1011, 2'd1, 1'b1, 2'd3, 9,  1'b1, 2'd1, 6,  4'b0011, 1'b0};
        tbl[11] = '{4'b1011, 2'd2, 1'b1, 2'd3, 10, 1'b1, 2'd0, 7,  4'b0011, 1'b0};
        tbl[12] = '{4'b0000, 2'd1, 1'b1, 2'd3, 11, 1'b1, 2'd1, 7,  4'b0011, 1'b1};
        tbl[13] = '{4'b0000, 2'd2, 1'b1, 2'd0, 8,  1'b1, 2'd1, 8,  4'b0011, 1'b1};
        tbl[14] = '{4'b0000, 2'd2, 1'b1, 2'd0, 9,  1'b1, 2'd1, 9,  4'b0001, 1'b1};
        tbl[15] = '{4'b0000, 2'd2, 1'b1, 2'd0, 10, 1'b1, 2'd1, 10, 4'b0000, 1'b1};
        tbl[16] = '{4'b0000, 2'd2, 1'b1, 2'd0, 11, 1'b0, 2'd0, 0,  4'b0000, 1'b1};
        tbl[17] = '{4'b0000, 2'd1, 1'b0, 2'd0, 0,  1'b0, 2'd0, 0,  4'b0000, 1'b1};

        rst   = 1'b1;
        flush = 1'b0;
        drive(4'b0000, 0);

        repeat (2) @(negedge clk);
        #1;
        chk_idle("reset");
        chk_val("reset fu_stall", 32'(fu_stall), 32'h0);
        chk_val("reset overflow", 32'(overflow_err), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_idle("post-reset");
        chk_val("post-reset rr_ptr", 32'(u_dut.rr_ptr), 32'h0);

        for (int unsigned r = 0; r < 18; r++) begin
            @(negedge clk);
            drive(tbl[r].mask, int'(r));
            #1;
            e0 = tbl[r].v0 ? mk(tbl[r].s0, tbl[r].q0) : cdb_t'('0);
            e1 = tbl[r].v1 ? mk(tbl[r].s1, tbl[r].q1) : cdb_t'('0);
            chk_pkt($sformatf("row%0d out0", r), cdb_out[0], e0);
            chk_pkt($sformatf("row%0d out1", r), cdb_out[1], e1);
            chk_val($sformatf("row%0d rr_ptr", r), 32'(u_dut.rr_ptr), 32'(tbl[r].rr));
            chk_val($sformatf("row%0d fu_stall", r), 32'(fu_stall), 32'(tbl[r].stall));
            chk_val($sformatf("row%0d overflow", r), 32'(overflow_err), 32'(tbl[r].ovf));
        end

        // Flush with three packets buffered and fresh valid inputs in the flush cycle.
        @(negedge clk);
        drive(4'b0111, 20);
        #1;
        chk_idle("pre-flush");
        @(negedge clk);
        flush = 1'b1;
        drive(4'b1111, 21);
        #1;
        chk_idle("flush cycle");
        @(negedge clk);
        flush = 1'b0;
        drive(4'b0000, 0);
        #1;
        chk_idle("after flush");
        chk_val("after flush rr_ptr", 32'(u_dut.rr_ptr), 32'h0);
        chk_val("after flush fu_stall", 32'(fu_stall), 32'h0);
        chk_val("after flush overflow", 32'(overflow_err), 32'h1);

        // Reset while add and mul FIFOs hold data.
        @(negedge clk);
        drive(4'b0011, 40);
        @(negedge clk);
        drive(4'b0000, 0);
        rst = 1'b1;
        #1;
        chk_idle("mid-reset");
        chk_val("mid-reset fu_stall", 32'(fu_stall), 32'h0);
        chk_val("mid-reset overflow", 32'(overflow_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0001, 41);
        #1;
        chk_idle("reset release");
        chk_val("reset release rr_ptr", 32'(u_dut.rr_ptr), 32'h0);
        chk_val("reset release overflow", 32'(overflow_err), 32'h0);
        @(negedge clk);
        drive(4'b0000, 0);
        #1;
        chk_pkt("first push after reset out0", cdb_out[0], mk(2'd0, 41));
        chk_pkt("first push after reset out1", cdb_out[1], '0);

        // Single add result with explicit field values.
        @(negedge clk);
        pkt         = '0;
        pkt.valid   = 1'b1;
        pkt.rob_idx = 5'd5;
        pkt.pd      = 6'd7;
        pkt.rd_v    = 32'h0000_1234;
        cdb_in[0]   = pkt;
        #1;
        chk_idle("single add push cycle");
        @(negedge clk);
        drive(4'b0000, 0);
        #1;
        chk_pkt("single add out0", cdb_out[0], pkt);
        chk_pkt("single add out1", cdb_out[1], '0);
        @(negedge clk);
        #1;
        chk_idle("single add drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
